// File: rtl/instr_encoder_loader_if.sv
// Instruction stream in / encoded word out bundle between the boot loader source and IMEM.
// The loader itself takes the slave view; the source/IMEM side takes the master view.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_index;
  logic [25:0]       in_opnd;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_index, in_opnd, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, in_index, in_opnd, in_last, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs (index, operand) pairs into 32-bit MIPS words and streams them to IMEM
// at an auto-incrementing address; the inverse of the CPU instruction decoder.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for base_load; no input accepted
// RUN   | accepting instructions, emitting encoded words
// DRAIN | last instruction taken; waiting for the pending word to leave
// DONE  | program complete; done pulses on the following cycle
module instr_encoder_loader #(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  base_load,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encoder_loader_if.slave bus,
  output logic [CNT_W-1:0]      word_count,
  output logic                  err_illegal,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              out_valid_q;
  logic [31:0]       out_word_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              in_ready_c;
  logic              accept;
  logic              handshake;
  logic [32:0]       enc;

  function automatic logic [32:0] rtype(input logic [19:0] keep, input logic [5:0] funct);
    return {1'b1, 6'h00, keep, funct};
  endfunction

  function automatic logic [32:0] itype(input logic [5:0] op, input logic [25:0] keep);
    return {1'b1, op, keep};
  endfunction

  function automatic logic [32:0] special2(input logic [14:0] keep, input logic [5:0] funct);
    return {1'b1, 6'h1C, keep, 5'b00000, funct};
  endfunction

  function automatic logic [32:0] cop0(input logic [4:0] rs, input logic [9:0] keep);
    return {1'b1, 6'h10, rs, keep, 11'b0};
  endfunction

  function automatic logic [32:0] bgez(input logic [4:0] rs, input logic [15:0] imm);
    return {1'b1, 6'h01, rs, 5'b00001, imm};
  endfunction

  // Returns {legal, word}; legal=0 for indices outside 1..54.
  function automatic logic [32:0] encode(input logic [5:0] idx, input logic [25:0] opnd);
    logic [32:0] r;
    r = '0;
    case (idx)
      6'd1:  r = itype(6'h08, opnd);
      6'd2:  r = itype(6'h09, opnd);
      6'd3:  r = itype(6'h0C, opnd);
      6'd4:  r = itype(6'h0D, opnd);
      6'd5:  r = itype(6'h0B, opnd);
      6'd6:  r = itype(6'h0F, opnd);
      6'd7:  r = itype(6'h0E, opnd);
      6'd8:  r = itype(6'h0A, opnd);
      6'd9:  r = rtype(opnd[25:6], 6'h21);
      6'd10: r = rtype(opnd[25:6], 6'h24);
      6'd11: r = itype(6'h04, opnd);
      6'd12: r = itype(6'h05, opnd);
      6'd13: r = itype(6'h02, opnd);
      6'd14: r = itype(6'h03, opnd);
      6'd15: r = rtype(opnd[25:6], 6'h08);
      6'd16: r = itype(6'h23, opnd);
      6'd17: r = rtype(opnd[25:6], 6'h26);
      6'd18: r = rtype(opnd[25:6], 6'h27);
      6'd19: r = rtype(opnd[25:6], 6'h25);
      6'd20: r = rtype(opnd[25:6], 6'h00);
      6'd21: r = rtype(opnd[25:6], 6'h04);
      6'd22: r = rtype(opnd[25:6], 6'h2B);
      6'd23: r = rtype(opnd[25:6], 6'h03);
      6'd24: r = rtype(opnd[25:6], 6'h02);
      6'd25: r = rtype(opnd[25:6], 6'h23);
      6'd26: r = itype(6'h2B, opnd);
      6'd27: r = rtype(opnd[25:6], 6'h20);
      6'd28: r = rtype(opnd[25:6], 6'h22);
      6'd29: r = rtype(opnd[25:6], 6'h2A);
      6'd30: r = rtype(opnd[25:6], 6'h06);
      6'd31: r = rtype(opnd[25:6], 6'h07);
      6'd32: r = special2(opnd[25:11], 6'h20);
      6'd33: r = rtype(opnd[25:6], 6'h1B);
      6'd34: r = {1'b1, 32'h4200_0018};
      6'd35: r = rtype(opnd[25:6], 6'h09);
      6'd36: r = itype(6'h20, opnd);
      6'd37: r = itype(6'h24, opnd);
      6'd38: r = itype(6'h25, opnd);
      6'd39: r = itype(6'h28, opnd);
      6'd40: r = itype(6'h29, opnd);
      6'd41: r = itype(6'h21, opnd);
      6'd42: r = cop0(5'b00000, opnd[20:11]);
      6'd43: r = rtype(opnd[25:6], 6'h10);
      6'd44: r = rtype(opnd[25:6], 6'h12);
      6'd45: r = cop0(5'b00100, opnd[20:11]);
      6'd46: r = rtype(opnd[25:6], 6'h11);
      6'd47: r = rtype(opnd[25:6], 6'h13);
      6'd48: r = special2(opnd[25:11], 6'h02);
      6'd49: r = rtype(opnd[25:6], 6'h19);
      6'd50: r = rtype(opnd[25:6], 6'h0C);
      6'd51: r = rtype(opnd[25:6], 6'h34);
      6'd52: r = bgez(opnd[25:21], opnd[15:0]);
      6'd53: r = rtype(opnd[25:6], 6'h0D);
      6'd54: r = rtype(opnd[25:6], 6'h1A);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign enc       = encode(bus.in_index, bus.in_opnd);
  assign accept    = bus.in_valid & in_ready_c;
  assign handshake = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (base_load) state_nxt = S_RUN;
      S_RUN:   if (accept && bus.in_last) state_nxt = S_DRAIN;
      S_DRAIN: if (!out_valid_q || bus.out_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    if (state == S_RUN) in_ready_c = !out_valid_q || bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_IDLE && base_load) begin
        addr        <= base_addr;
        word_count  <= '0;
        err_illegal <= 1'b0;
      end
      // A new accept overrides the handshake clear so streaming has no bubble.
      if (accept && enc[32]) begin
        out_word_q  <= enc[31:0];
        out_addr_q  <= addr;
        out_valid_q <= 1'b1;
        addr        <= addr + ADDR_W'(ADDR_STEP);
        word_count  <= word_count + CNT_W'(1);
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !enc[32]) err_illegal <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: words are queued as they are accepted
// and compared in order when IMEM takes them.
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        base_load;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        err_illegal;
  logic        done;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(32)) ifc ();

  instr_encoder_loader #(.ADDR_W(32), .ADDR_STEP(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base_load   (base_load),
    .base_addr   (base_addr),
    .bus         (ifc.slave),
    .word_count  (word_count),
    .err_illegal (err_illegal),
    .done        (done)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_word[$];
  logic [31:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshake completes on the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (q_word.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_word: observed %h expected none", ifc.out_word);
      end else begin
        chk("out_addr", ifc.out_addr, q_addr.pop_front());
        chk("out_word", ifc.out_word, q_word.pop_front());
      end
    end
  end

  task automatic start(input logic [31:0] base);
    @(posedge clk); #1;
    base_load = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    base_load = 1'b0;
    exp_addr  = base;
  endtask

  task automatic send(input logic [5:0] idx, input logic [25:0] opnd, input logic last,
                      input logic legal, input logic [31:0] w);
    int t;
    t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_index = idx;
    ifc.in_opnd  = opnd;
    ifc.in_last  = last;
    forever begin
      @(negedge clk);
      if (ifc.in_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 32'(ifc.in_ready), 32'd1);
        break;
      end
    end
    if (legal && ifc.in_ready === 1'b1) begin
      q_addr.push_back(exp_addr);
      q_word.push_back(w);
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_queue_drained"}, 32'(q_word.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n         = 1'b0;
    base_load     = 1'b0;
    base_addr     = '0;
    ifc.in_valid  = 1'b0;
    ifc.in_index  = '0;
    ifc.in_opnd   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    exp_addr      = '0;
    #12;
    chk("rst_in_ready",    32'(ifc.in_ready),  32'd0);
    chk("rst_out_valid",   32'(ifc.out_valid), 32'd0);
    chk("rst_out_word",    ifc.out_word,       32'd0);
    chk("rst_out_addr",    ifc.out_addr,       32'd0);
    chk("rst_word_count",  32'(word_count),    32'd0);
    chk("rst_err_illegal", 32'(err_illegal),   32'd0);
    chk("rst_done",        32'(done),          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic packing: addi, addu, j
    start(32'h0040_0000);
    send(6'd1,  {5'd2, 5'd3, 16'h0005}, 1'b0, 1'b1, 32'h2043_0005);
    send(6'd9,  {5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 1'b0, 1'b1, 32'h0022_1821);
    send(6'd13, 26'h010_0000, 1'b1, 1'b1, 32'h0810_0000);
    wait_done("pack");
    chk("pack_word_count", 32'(word_count), 32'd3);

    // Forced fields: eret, bgez, mfc0
    start(32'h0000_0100);
    send(6'd34, '1, 1'b0, 1'b1, 32'h4200_0018);
    send(6'd52, {5'd4, 5'd0, 16'hFFFE}, 1'b0, 1'b1, 32'h0481_FFFE);
    send(6'd42, {5'h1F, 5'd8, 5'd12, 11'h7FF}, 1'b1, 1'b1, 32'h4008_6000);
    wait_done("forced");
    chk("forced_word_count", 32'(word_count), 32'd3);
    chk("forced_err",        32'(err_illegal), 32'd0);

    // Backpressure: word held for three stalled cycles, then streamed
    start(32'h0000_2000);
    ifc.out_ready = 1'b0;
    send(6'd1, 26'd1, 1'b0, 1'b1, 32'h2000_0001);
    fork
      begin
        send(6'd1, 26'd2, 1'b0, 1'b1, 32'h2000_0002);
        send(6'd1, 26'd3, 1'b0, 1'b1, 32'h2000_0003);
        send(6'd1, 26'd4, 1'b1, 1'b1, 32'h2000_0004);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready",  32'(ifc.in_ready),  32'd0);
          chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
          chk("bp_word_held", ifc.out_word, 32'h2000_0001);
          chk("bp_addr_held", ifc.out_addr, 32'h0000_2000);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_stream_ready", 32'(ifc.in_ready), 32'd1);
        chk("bp_stream_word",  ifc.out_word, 32'h2000_0002);
      end
    join
    wait_done("bp");
    chk("bp_word_count", 32'(word_count), 32'd4);

    // Illegal indices in the middle of a program
    start(32'h0000_3000);
    send(6'd1,  26'd5, 1'b0, 1'b1, 32'h2000_0005);
    send(6'd0,  26'd9, 1'b0, 1'b0, 32'h0);
    send(6'd55, 26'd9, 1'b0, 1'b0, 32'h0);
    send(6'd2,  26'd7, 1'b0, 1'b1, 32'h2400_0007);
    chk("ill_err_set", 32'(err_illegal), 32'd1);
    send(6'd8,  26'd3, 1'b1, 1'b1, 32'h2800_0003);
    wait_done("ill");
    chk("ill_word_count", 32'(word_count), 32'd3);
    chk("ill_err_sticky", 32'(err_illegal), 32'd1);

    // Address wrap; base_load while running is ignored
    start(32'hFFFF_FFFC);
    chk("wrap_err_cleared", 32'(err_illegal), 32'd0);
    chk("wrap_count_clear", 32'(word_count),  32'd0);
    send(6'd36, 26'd3, 1'b0, 1'b1, 32'h8000_0003);
    base_load = 1'b1;
    base_addr = 32'h0000_5550;
    @(posedge clk); #1;
    base_load = 1'b0;
    send(6'd13, 26'd4, 1'b1, 1'b1, 32'h0800_0004);
    wait_done("wrap");
    chk("wrap_word_count", 32'(word_count), 32'd2);

    // Illegal final instruction still ends the program
    start(32'h0000_6000);
    send(6'd11, 26'h1234, 1'b0, 1'b1, 32'h1000_1234);
    send(6'd63, 26'h0,    1'b1, 1'b0, 32'h0);
    wait_done("illast");
    chk("illast_count", 32'(word_count),  32'd1);
    chk("illast_err",   32'(err_illegal), 32'd1);

    // Asynchronous reset with a word pending
    start(32'h0000_7000);
    ifc.out_ready = 1'b0;
    send(6'd1, 26'h9, 1'b0, 1'b1, 32'h2000_0009);
    chk("mid_pending", 32'(ifc.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    q_addr.delete();
    q_word.delete();
    chk("mid_out_valid",  32'(ifc.out_valid), 32'd0);
    chk("mid_out_word",   ifc.out_word,       32'd0);
    chk("mid_out_addr",   ifc.out_addr,       32'd0);
    chk("mid_word_count", 32'(word_count),    32'd0);
    chk("mid_in_ready",   32'(ifc.in_ready),  32'd0);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start(32'h0000_8000);
    send(6'd14, 26'h10, 1'b1, 1'b1, 32'h0C00_0010);
    wait_done("restart");
    chk("restart_count", 32'(word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
